// File: rtl/branch_predictor_bht_pkg.sv
// Shared constants and helpers for the branch predictor BHT/BTB block.
package branch_predictor_bht_pkg;

   // Width of every program-counter and target bus.
   localparam int PC_BUS = 32;

   // The mispredict counter sticks at this value.
   localparam logic [31:0] MISPRED_MAX = 32'hFFFF_FFFF;

   // Weakly not-taken start value for a counter of the given width:
   // 01 for 2-bit counters, 0 for a 1-bit counter.
   function automatic int bp_cnt_init(input int cnt_bits);
      return (1 << (cnt_bits - 1)) - 1;
   endfunction

endpackage

// File: rtl/bp_sat_cnt.sv
// One saturating up/down counter of the branch history table.
// init (table sweep) has priority over inc/dec; inc and dec are never both set.
module bp_sat_cnt
   import branch_predictor_bht_pkg::*;
#(
   parameter int CNT_BITS = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                init,
   input  logic                inc,
   input  logic                dec,
   output logic [CNT_BITS-1:0] cnt
);

   localparam logic [CNT_BITS-1:0] CNT_INIT = CNT_BITS'(bp_cnt_init(CNT_BITS));
   localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;

   logic [CNT_BITS-1:0] cnt_reg;
   logic [CNT_BITS-1:0] cnt_next;

   // Next value: sweep re-init, otherwise step toward the outcome and hold at the rails.
   always_comb begin
      cnt_next = cnt_reg;
      if (init) begin
         cnt_next = CNT_INIT;
      end else if (inc && (cnt_reg != CNT_MAX)) begin
         cnt_next = cnt_reg + CNT_BITS'(1);
      end else if (dec && (cnt_reg != '0)) begin
         cnt_next = cnt_reg - CNT_BITS'(1);
      end
   end

   // Counter state; reset puts it at weakly not-taken.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_reg <= CNT_INIT;
      end else begin
         cnt_reg <= cnt_next;
      end
   end

   assign cnt = cnt_reg;

endmodule

// File: rtl/branch_predictor_bht.sv
// Dual-issue fetch branch predictor: per-PC saturating-counter BHT plus a
// direct-mapped BTB, N_SLOT combinational predictions per fetch group, one
// resolved-branch update per cycle, a table-clear sweep and a mispredict counter.
module branch_predictor_bht
   import branch_predictor_bht_pkg::*;
#(
   parameter int N_SLOT    = 2,
   parameter int BHT_DEPTH = 64,
   parameter int CNT_BITS  = 2,
   parameter int BTB_DEPTH = 16,
   parameter int TAG_BITS  = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [PC_BUS-1:0]        lookup_pc,
   output logic [N_SLOT-1:0]        pred_taken,
   output logic [N_SLOT-1:0]        pred_hit,
   output logic [PC_BUS*N_SLOT-1:0] pred_target,
   input  logic                     upd_valid,
   input  logic [PC_BUS-1:0]        upd_pc,
   input  logic                     upd_taken,
   input  logic [PC_BUS-1:0]        upd_target,
   input  logic                     upd_mispredict,
   input  logic                     clear,
   output logic                     busy,
   output logic [31:0]              mispred_cnt
);

   localparam int BHT_IW      = $clog2(BHT_DEPTH);
   localparam int BTB_IW      = $clog2(BTB_DEPTH);
   localparam int SWEEP_DEPTH = (BHT_DEPTH > BTB_DEPTH) ? BHT_DEPTH : BTB_DEPTH;
   localparam int PTR_W       = $clog2(SWEEP_DEPTH);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(SWEEP_DEPTH - 1);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SWEEP = 1'b1
   } sweep_state_t;

   sweep_state_t            state_reg;
   logic [PTR_W-1:0]        sweep_ptr_reg;
   logic                    busy_reg;
   logic [31:0]             mispred_cnt_reg;

   logic                    upd_accept;
   logic                    sweep_active;
   logic [BHT_IW-1:0]       upd_bht_idx;
   logic [BTB_IW-1:0]       upd_btb_idx;
   logic [TAG_BITS-1:0]     upd_tag;

   logic [CNT_BITS-1:0]     cnt_val        [BHT_DEPTH];
   logic                    btb_valid_reg  [BTB_DEPTH];
   logic [TAG_BITS-1:0]     btb_tag_reg    [BTB_DEPTH];
   logic [PC_BUS-1:0]       btb_target_reg [BTB_DEPTH];

   logic [N_SLOT-1:0][PC_BUS-1:0] slot_pc;
   logic                    unused_pc_bits;

   // Updates are only taken while the sweep is idle; busy is the registered sweep flag.
   assign upd_accept   = upd_valid && !busy_reg;
   assign sweep_active = (state_reg == ST_SWEEP);
   assign upd_bht_idx  = upd_pc[BHT_IW+1:2];
   assign upd_btb_idx  = upd_pc[BTB_IW+1:2];
   assign upd_tag      = upd_pc[TAG_BITS+BTB_IW+1:BTB_IW+2];

   // Clear-sweep FSM: walks the pointer across the larger table, busy follows the state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg     <= ST_IDLE;
         sweep_ptr_reg <= '0;
         busy_reg      <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (clear) begin
                  state_reg     <= ST_SWEEP;
                  sweep_ptr_reg <= '0;
                  busy_reg      <= 1'b1;
               end
            end
            ST_SWEEP: begin
               if (sweep_ptr_reg == PTR_LAST) begin
                  state_reg     <= ST_IDLE;
                  sweep_ptr_reg <= '0;
                  busy_reg      <= 1'b0;
               end else begin
                  sweep_ptr_reg <= sweep_ptr_reg + PTR_W'(1);
               end
            end
            default: begin
               state_reg     <= ST_IDLE;
               sweep_ptr_reg <= '0;
               busy_reg      <= 1'b0;
            end
         endcase
      end
   end

   // Mispredict counter: counts accepted mispredict updates, sticks at all-ones, survives sweeps.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mispred_cnt_reg <= '0;
      end else if (upd_accept && upd_mispredict && (mispred_cnt_reg != MISPRED_MAX)) begin
         mispred_cnt_reg <= mispred_cnt_reg + 32'd1;
      end
   end

   // BHT: one counter per entry, stepped by the matching update, re-initialised by the sweep.
   generate
      for (genvar gi = 0; gi < BHT_DEPTH; gi++) begin : g_bht
         logic upd_here;
         logic sweep_here;

         assign upd_here   = upd_accept && (upd_bht_idx == BHT_IW'(gi));
         assign sweep_here = sweep_active && (sweep_ptr_reg == PTR_W'(gi));

         bp_sat_cnt #(
            .CNT_BITS (CNT_BITS)
         ) u_cnt (
            .clk  (clk),
            .rst  (rst),
            .init (sweep_here),
            .inc  (upd_here && upd_taken),
            .dec  (upd_here && !upd_taken),
            .cnt  (cnt_val[gi])
         );
      end
   endgenerate

   // BTB: per-entry registers so reset and the sweep can clear every entry.
   generate
      for (genvar gi = 0; gi < BTB_DEPTH; gi++) begin : g_btb
         // Entry state: cleared by reset/sweep, overwritten by a taken update that indexes it.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               btb_valid_reg[gi]  <= 1'b0;
               btb_tag_reg[gi]    <= '0;
               btb_target_reg[gi] <= '0;
            end else if (sweep_active && (sweep_ptr_reg == PTR_W'(gi))) begin
               btb_valid_reg[gi]  <= 1'b0;
               btb_tag_reg[gi]    <= '0;
               btb_target_reg[gi] <= '0;
            end else if (upd_accept && upd_taken && (upd_btb_idx == BTB_IW'(gi))) begin
               btb_valid_reg[gi]  <= 1'b1;
               btb_tag_reg[gi]    <= upd_tag;
               btb_target_reg[gi] <= upd_target;
            end
         end
      end
   endgenerate

   // Lookup: pure combinational read of the registered tables, muted while sweeping.
   generate
      for (genvar gi = 0; gi < N_SLOT; gi++) begin : g_slot
         logic [BHT_IW-1:0]   bht_idx;
         logic [BTB_IW-1:0]   btb_idx;
         logic [TAG_BITS-1:0] tag;
         logic                hit;

         assign slot_pc[gi] = lookup_pc + PC_BUS'(4 * gi);
         assign bht_idx     = slot_pc[gi][BHT_IW+1:2];
         assign btb_idx     = slot_pc[gi][BTB_IW+1:2];
         assign tag         = slot_pc[gi][TAG_BITS+BTB_IW+1:BTB_IW+2];
         assign hit         = !busy_reg && btb_valid_reg[btb_idx] && (btb_tag_reg[btb_idx] == tag);

         assign pred_hit[gi]                        = hit;
         assign pred_taken[gi]                      = hit && cnt_val[bht_idx][CNT_BITS-1];
         assign pred_target[PC_BUS*gi +: PC_BUS]    = hit ? btb_target_reg[btb_idx] : '0;
      end
   endgenerate

   // PC bits outside the index/tag fields carry no information for the predictor.
   assign unused_pc_bits = ^{slot_pc, upd_pc};

   assign busy        = busy_reg;
   assign mispred_cnt = mispred_cnt_reg;

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Self-checking bench for branch_predictor_bht: table-level behavioural model,
// per-cycle compare at the falling edge, directed cases plus random traffic.
module tb_branch_predictor_bht;

   localparam int N_SLOT      = 2;
   localparam int BHT_DEPTH   = 64;
   localparam int CNT_BITS    = 2;
   localparam int BTB_DEPTH   = 16;
   localparam int TAG_BITS    = 8;
   localparam int SWEEP_DEPTH = 64;
   localparam int CNT_MAX     = 3;
   localparam int CNT_INIT    = 1;
   localparam int CNT_THRESH  = 2;

   logic                 clk = 1'b0;
   logic                 rst = 1'b0;
   logic [31:0]          lookup_pc = '0;
   logic [N_SLOT-1:0]    pred_taken;
   logic [N_SLOT-1:0]    pred_hit;
   logic [32*N_SLOT-1:0] pred_target;
   logic                 upd_valid = 1'b0;
   logic [31:0]          upd_pc = '0;
   logic                 upd_taken = 1'b0;
   logic [31:0]          upd_target = '0;
   logic                 upd_mispredict = 1'b0;
   logic                 clear = 1'b0;
   logic                 busy;
   logic [31:0]          mispred_cnt;

   int n_checks = 0;
   int n_errors = 0;

   branch_predictor_bht #(
      .N_SLOT    (N_SLOT),
      .BHT_DEPTH (BHT_DEPTH),
      .CNT_BITS  (CNT_BITS),
      .BTB_DEPTH (BTB_DEPTH),
      .TAG_BITS  (TAG_BITS)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .lookup_pc      (lookup_pc),
      .pred_taken     (pred_taken),
      .pred_hit       (pred_hit),
      .pred_target    (pred_target),
      .upd_valid      (upd_valid),
      .upd_pc         (upd_pc),
      .upd_taken      (upd_taken),
      .upd_target     (upd_target),
      .upd_mispredict (upd_mispredict),
      .clear          (clear),
      .busy           (busy),
      .mispred_cnt    (mispred_cnt)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   int          m_cnt   [BHT_DEPTH];
   bit          m_valid [BTB_DEPTH];
   int unsigned m_tag   [BTB_DEPTH];
   logic [31:0] m_tgt   [BTB_DEPTH];
   int          m_sweep_left;
   logic [31:0] m_mis;

   function automatic void model_reset();
      for (int i = 0; i < BHT_DEPTH; i++) m_cnt[i] = CNT_INIT;
      for (int i = 0; i < BTB_DEPTH; i++) begin
         m_valid[i] = 1'b0;
         m_tag[i]   = 0;
         m_tgt[i]   = '0;
      end
      m_sweep_left = 0;
      m_mis        = '0;
   endfunction

   function automatic void model_step();
      int p;
      int bi;
      int ti;
      if (m_sweep_left > 0) begin
         p = SWEEP_DEPTH - m_sweep_left;
         if (p < BHT_DEPTH) m_cnt[p] = CNT_INIT;
         if (p < BTB_DEPTH) begin
            m_valid[p] = 1'b0;
            m_tag[p]   = 0;
            m_tgt[p]   = '0;
         end
         m_sweep_left = m_sweep_left - 1;
      end else begin
         if (upd_valid) begin
            bi = int'((upd_pc / 4) % BHT_DEPTH);
            ti = int'((upd_pc / 4) % BTB_DEPTH);
            if (upd_taken) begin
               if (m_cnt[bi] < CNT_MAX) m_cnt[bi] = m_cnt[bi] + 1;
               m_valid[ti] = 1'b1;
               m_tag[ti]   = int'((upd_pc / (4 * BTB_DEPTH)) % 256);
               m_tgt[ti]   = upd_target;
            end else begin
               if (m_cnt[bi] > 0) m_cnt[bi] = m_cnt[bi] - 1;
            end
            if (upd_mispredict && (m_mis != 32'hFFFF_FFFF)) m_mis = m_mis + 32'd1;
         end
         if (clear) m_sweep_left = SWEEP_DEPTH;
      end
   endfunction

   function automatic void exp_pred(input logic [31:0] lpc,
                                    output logic [N_SLOT-1:0] et,
                                    output logic [N_SLOT-1:0] eh,
                                    output logic [63:0] etg);
      logic [31:0] pc;
      int bi;
      int ti;
      et  = '0;
      eh  = '0;
      etg = '0;
      if (m_sweep_left == 0) begin
         for (int s = 0; s < N_SLOT; s++) begin
            pc = lpc + 32'(4 * s);
            bi = int'((pc / 4) % BHT_DEPTH);
            ti = int'((pc / 4) % BTB_DEPTH);
            if (m_valid[ti] && (m_tag[ti] == int'((pc / (4 * BTB_DEPTH)) % 256))) begin
               eh[s]            = 1'b1;
               et[s]            = (m_cnt[bi] >= CNT_THRESH);
               etg[32*s +: 32]  = m_tgt[ti];
            end
         end
      end
   endfunction

   // Model state advances on the same edges as the design.
   always @(posedge clk or negedge rst) begin
      if (!rst) model_reset();
      else      model_step();
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks = n_checks + 1;
      if (act !== exp) begin
         n_errors = n_errors + 1;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Per-cycle compare of every output against the model.
   always @(negedge clk) begin
      logic [N_SLOT-1:0] et;
      logic [N_SLOT-1:0] eh;
      logic [63:0]       etg;
      exp_pred(lookup_pc, et, eh, etg);
      chk("pred_taken",  64'(pred_taken),  64'(et));
      chk("pred_hit",    64'(pred_hit),    64'(eh));
      chk("pred_target", 64'(pred_target), etg);
      chk("busy",        64'(busy),        64'(m_sweep_left > 0));
      chk("mispred_cnt", 64'(mispred_cnt), 64'(m_mis));
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_upd(input logic [31:0] pc, input logic tk,
                         input logic [31:0] tgt, input logic mis);
      upd_valid      = 1'b1;
      upd_pc         = pc;
      upd_taken      = tk;
      upd_target     = tgt;
      upd_mispredict = mis;
      $display("upd pc=%h taken=%0d target=%h mis=%0d busy=%0d", pc, tk, tgt, mis, busy);
      tick();
      upd_valid      = 1'b0;
      upd_mispredict = 1'b0;
   endtask

   int busy_cycles;

   initial begin
      model_reset();
      // 1: reset state
      rst       = 1'b0;
      lookup_pc = 32'h100;
      @(negedge clk);
      chk("rst_busy",    64'(busy),        64'd0);
      chk("rst_mispred", 64'(mispred_cnt), 64'd0);
      chk("rst_hit",     64'(pred_hit),    64'd0);
      chk("rst_taken",   64'(pred_taken),  64'd0);
      tick();
      rst = 1'b1;
      tick();

      // 2: single taken update, then slot 0 and slot 1 lookups
      do_upd(32'h100, 1'b1, 32'h40, 1'b0);
      lookup_pc = 32'h100;
      @(negedge clk);
      chk("t2_hit0",    64'(pred_hit[0]),         64'd1);
      chk("t2_taken0",  64'(pred_taken[0]),       64'd1);
      chk("t2_target0", 64'(pred_target[31:0]),   64'h40);
      tick();
      lookup_pc = 32'h0FC;
      @(negedge clk);
      chk("t2_taken_s1",  64'(pred_taken),         64'b10);
      chk("t2_target_s1", 64'(pred_target[63:32]), 64'h40);
      tick();

      // 3: saturation at 0x200
      lookup_pc = 32'h200;
      repeat (4) do_upd(32'h200, 1'b1, 32'h80, 1'b0);
      do_upd(32'h200, 1'b0, 32'h0, 1'b1);
      @(negedge clk);
      chk("t3_still_taken", 64'(pred_taken[0]), 64'd1);
      tick();
      repeat (2) do_upd(32'h200, 1'b0, 32'h0, 1'b1);
      @(negedge clk);
      chk("t3_not_taken", 64'(pred_taken[0]), 64'd0);
      chk("t3_hit",       64'(pred_hit[0]),   64'd1);
      tick();

      // 4: BTB aliasing (same index, different tag)
      do_upd(32'h100, 1'b1, 32'h44, 1'b0);
      do_upd(32'h140, 1'b1, 32'h48, 1'b0);
      lookup_pc = 32'h100;
      @(negedge clk);
      chk("t4_alias_miss", 64'(pred_hit), 64'b00);
      tick();
      lookup_pc = 32'h140;
      @(negedge clk);
      chk("t4_alias_hit", 64'(pred_hit), 64'b01);
      tick();

      // 5: clear sweep with a dropped concurrent update
      clear = 1'b1;
      tick();
      clear          = 1'b0;
      upd_valid      = 1'b1;
      upd_pc         = 32'h380;
      upd_taken      = 1'b1;
      upd_target     = 32'h99;
      upd_mispredict = 1'b1;
      busy_cycles    = 0;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (!busy) break;
         busy_cycles++;
         if (n == 0) chk("t5_muted_hit", 64'(pred_hit), 64'd0);
         tick();
         upd_valid      = 1'b0;
         upd_mispredict = 1'b0;
      end
      chk("t5_busy_cycles", 64'(busy_cycles), 64'd64);
      chk("t5_cleared_hit", 64'(pred_hit),    64'd0);
      chk("t5_mispred_kept", 64'(mispred_cnt), 64'd3);
      tick();
      lookup_pc = 32'h380;
      @(negedge clk);
      chk("t5_drop_upd", 64'(pred_hit), 64'd0);
      tick();

      // 6: same-cycle lookup and update
      lookup_pc  = 32'h300;
      upd_valid  = 1'b1;
      upd_pc     = 32'h300;
      upd_taken  = 1'b1;
      upd_target = 32'h1234;
      @(negedge clk);
      chk("t6_old_hit", 64'(pred_hit[0]), 64'd0);
      tick();
      upd_valid = 1'b0;
      @(negedge clk);
      chk("t6_new_taken",  64'(pred_taken[0]),     64'd1);
      chk("t6_new_target", 64'(pred_target[31:0]), 64'h1234);
      tick();

      // random traffic
      for (int i = 0; i < 1500; i++) begin
         lookup_pc      = 32'($urandom_range(0, 127)) << 3;
         upd_valid      = ($urandom_range(0, 9) < 6);
         upd_pc         = 32'($urandom_range(0, 255)) << 2;
         upd_taken      = 1'($urandom_range(0, 1));
         upd_target     = $urandom & 32'hFFFF_FFFC;
         upd_mispredict = ($urandom_range(0, 3) == 0);
         clear          = ($urandom_range(0, 299) == 0);
         if (upd_valid)
            $display("rnd upd pc=%h taken=%0d target=%h mis=%0d clear=%0d", upd_pc, upd_taken, upd_target, upd_mispredict, clear);
         tick();
      end
      upd_valid      = 1'b0;
      upd_mispredict = 1'b0;
      clear          = 1'b0;
      for (int n = 0; n < 100; n++) begin
         if (!busy) break;
         tick();
      end
      chk("rnd_idle", 64'(busy), 64'd0);

      // reset in the middle of a sweep
      clear = 1'b1;
      tick();
      clear = 1'b0;
      repeat (10) tick();
      #2 rst = 1'b0;
      @(negedge clk);
      chk("midrst_busy",    64'(busy),        64'd0);
      chk("midrst_mispred", 64'(mispred_cnt), 64'd0);
      #2 rst = 1'b1;
      tick();
      lookup_pc = 32'h300;
      do_upd(32'h300, 1'b1, 32'h55, 1'b0);
      @(negedge clk);
      chk("midrst_retrain", 64'(pred_taken), 64'b01);
      tick();

      // mispredict counter saturation
      force dut.mispred_cnt_reg = 32'hFFFF_FFFE;
      m_mis = 32'hFFFF_FFFE;
      #1 release dut.mispred_cnt_reg;
      repeat (3) do_upd(32'h10, 1'b0, 32'h0, 1'b1);
      @(negedge clk);
      chk("mis_saturate", 64'(mispred_cnt), 64'hFFFF_FFFF);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
